// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the N-master single-slave bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: fixed priority from index 0, or round-robin from ptr.
module arb_picker
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned IDX_W       = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  input  logic                   rr_mode,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IDX_W-1:0]       winner_idx
);

  int unsigned      start;
  int unsigned      pos;
  logic [IDX_W-1:0] p;
  logic             hit;

  // Scan from the start index with wrap; the first set request wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    hit        = 1'b0;
    pos        = 0;
    p          = '0;
    start      = rr_mode ? 32'(ptr) : 32'd0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      pos = (start + i) % NUM_MASTERS;
      p   = IDX_W'(pos);
      if (!hit && req[p]) begin
        hit        = 1'b1;
        winner[p]  = 1'b1;
        winner_idx = p;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-master to single-slave bus arbiter with registered grant, zero-latency
// ack/err return, abort on dropped request and a watchdog timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_MASTERS-1:0]        i_m_cs,
  input  logic [NUM_MASTERS-1:0]        i_m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat,
  output logic [NUM_MASTERS-1:0]        o_m_ack,
  output logic [NUM_MASTERS-1:0]        o_m_err,
  output logic [DATA_W-1:0]             o_m_dat,
  output logic [NUM_MASTERS-1:0]        o_grant,
  output logic [ADDR_W-1:0]             o_addr,
  output logic [DATA_W-1:0]             o_dat,
  output logic                          o_we,
  output logic                          o_cs,
  input  logic [DATA_W-1:0]             i_dat,
  input  logic                          i_ack
);

  localparam int unsigned IDX_W   = idx_w(NUM_MASTERS);
  localparam int unsigned CNT_W   = idx_w(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic        RR_MODE = (ARB_MODE == ARB_RR);

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       gidx;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       count;

  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   access;
  logic                   cs_g;
  logic                   timeout_hit;
  logic                   done;

  arb_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req       (i_m_cs),
    .ptr       (rr_ptr),
    .rr_mode   (RR_MODE),
    .winner    (pick),
    .winner_idx(pick_idx)
  );

  // Completion is decided by the registered owner, never by other requesters.
  assign access      = (state == ACCESS);
  assign cs_g        = access && i_m_cs[gidx];
  assign timeout_hit = TO_EN && cs_g && !i_ack && (count == CNT_W'(TO_LAST));
  assign done        = cs_g && (i_ack || timeout_hit);

  assign o_cs    = cs_g;
  assign o_grant = grant;
  assign o_m_ack = done ? grant : '0;
  assign o_m_err = timeout_hit ? grant : '0;
  assign o_m_dat = i_dat;
  assign o_addr  = access ? i_m_addr[gidx*ADDR_W +: ADDR_W] : '0;
  assign o_dat   = access ? i_m_dat[gidx*DATA_W +: DATA_W] : '0;
  assign o_we    = access && i_m_we[gidx];

  // Grant FSM, watchdog counter and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (|i_m_cs) begin
            state <= ACCESS;
            grant <= pick;
            gidx  <= pick_idx;
          end
        end
        ACCESS: begin
          if (done) begin
            state  <= IDLE;
            grant  <= '0;
            count  <= '0;
            rr_ptr <= (gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx + IDX_W'(1);
          end else if (!cs_g) begin
            state <= IDLE;
            grant <= '0;
            count <= '0;
          end else if (count != '1) begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: a fixed-priority instance (timeout 4) and a round-robin instance.
module tb_bus_arbiter;

  typedef struct packed {
    logic [2:0]  grant;
    logic        err;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdat;
  } exp_t;

  localparam logic [15:0] ADDR_T [3] = '{16'h1111, 16'h2222, 16'h3333};
  localparam logic [7:0]  WDAT_T [3] = '{8'hA1, 8'hB2, 8'hC3};
  localparam logic [2:0]  WE_V       = 3'b101;
  localparam logic [7:0]  F_RD       = 8'h5A;
  localparam logic [7:0]  R_RD       = 8'h3C;

  logic        i_clk;
  logic        i_reset_n;
  logic [47:0] m_addr;
  logic [23:0] m_dat;
  logic [2:0]  m_we;

  logic [2:0]  f_cs, f_m_ack, f_m_err, f_grant;
  logic        f_ack, f_we_o, f_cs_o;
  logic [7:0]  f_m_dat, f_dat_o;
  logic [15:0] f_addr_o;

  logic [2:0]  r_cs, r_m_ack, r_m_err, r_grant;
  logic        r_ack, r_we_o, r_cs_o;
  logic [7:0]  r_m_dat, r_dat_o;
  logic [15:0] r_addr_o;

  int   checks;
  int   errors;
  exp_t fq[$];
  exp_t rq[$];
  exp_t fe, re;

  bus_arbiter #(
    .NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8), .ARB_MODE(0), .TIMEOUT_CYCLES(4)
  ) u_fx (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m_cs(f_cs), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_dat(m_dat),
    .o_m_ack(f_m_ack), .o_m_err(f_m_err), .o_m_dat(f_m_dat), .o_grant(f_grant),
    .o_addr(f_addr_o), .o_dat(f_dat_o), .o_we(f_we_o), .o_cs(f_cs_o),
    .i_dat(F_RD), .i_ack(f_ack)
  );

  bus_arbiter #(
    .NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8), .ARB_MODE(1), .TIMEOUT_CYCLES(255)
  ) u_rr (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m_cs(r_cs), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_dat(m_dat),
    .o_m_ack(r_m_ack), .o_m_err(r_m_err), .o_m_dat(r_m_dat), .o_grant(r_grant),
    .o_addr(r_addr_o), .o_dat(r_dat_o), .o_we(r_we_o), .o_cs(r_cs_o),
    .i_dat(R_RD), .i_ack(r_ack)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] k, input logic err);
    exp_t e;
    e.grant = 3'(3'b001 << k);
    e.err   = err;
    e.addr  = ADDR_T[k];
    e.we    = WE_V[k];
    e.wdat  = WDAT_T[k];
    return e;
  endfunction

  task automatic check_ack(input string tag, input exp_t e, input logic [2:0] ack,
                           input logic [2:0] err, input logic [2:0] grant, input logic cs,
                           input logic [15:0] addr, input logic we, input logic [7:0] wd,
                           input logic [7:0] md, input logic [7:0] rd);
    chk({tag, "_ack"},   32'(ack),   32'(e.grant));
    chk({tag, "_err"},   32'(err),   32'(e.err ? e.grant : 3'b000));
    chk({tag, "_grant"}, 32'(grant), 32'(e.grant));
    chk({tag, "_cs"},    32'(cs),    32'(1'b1));
    chk({tag, "_addr"},  32'(addr),  32'(e.addr));
    chk({tag, "_we"},    32'(we),    32'(e.we));
    chk({tag, "_wdat"},  32'(wd),    32'(e.wdat));
    chk({tag, "_rdat"},  32'(md),    32'(rd));
  endtask

  // Monitors: every ack strobe must match the oldest expected completion.
  always @(negedge i_clk) begin
    if (f_m_ack != 3'b000) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fx_unexpected_ack actual=%b required=none", f_m_ack);
      end else begin
        fe = fq.pop_front();
        check_ack("fx", fe, f_m_ack, f_m_err, f_grant, f_cs_o, f_addr_o, f_we_o, f_dat_o,
                  f_m_dat, F_RD);
      end
    end
  end

  always @(negedge i_clk) begin
    if (r_m_ack != 3'b000) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexpected_ack actual=%b required=none", r_m_ack);
      end else begin
        re = rq.pop_front();
        check_ack("rr", re, r_m_ack, r_m_err, r_grant, r_cs_o, r_addr_o, r_we_o, r_dat_o,
                  r_m_dat, R_RD);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    i_reset_n = 1'b1;
    f_cs = 3'b000; r_cs = 3'b000; f_ack = 1'b0; r_ack = 1'b0;
    m_we   = WE_V;
    m_addr = {ADDR_T[2], ADDR_T[1], ADDR_T[0]};
    m_dat  = {WDAT_T[2], WDAT_T[1], WDAT_T[0]};
    #1 i_reset_n = 1'b0;
    #2;
    chk("rst_cs",    32'(f_cs_o),   32'(1'b0));
    chk("rst_grant", 32'(f_grant),  32'(3'b000));
    chk("rst_ack",   32'(f_m_ack),  32'(3'b000));
    chk("rst_err",   32'(f_m_err),  32'(3'b000));
    chk("rst_addr",  32'(f_addr_o), 32'(16'h0000));
    chk("rst_dat",   32'(f_dat_o),  32'(8'h00));
    chk("rst_we",    32'(f_we_o),   32'(1'b0));
    chk("rst_mdat",  32'(f_m_dat),  32'(F_RD));
    chk("rst_rr_grant", 32'(r_grant), 32'(3'b000));
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_reset_n = 1'b1;

    // Fixed priority: 110 grants master 1, then master 2 after one idle cycle.
    tick(); f_ack = 1'b1; f_cs = 3'b110;
    fq.push_back(mk(2'd1, 1'b0));
    fq.push_back(mk(2'd2, 1'b0));
    @(negedge i_clk) chk("fx_grant_latency", 32'(f_grant), 32'(3'b000));
    tick();
    tick(); f_cs = 3'b100;
    @(negedge i_clk);
    chk("fx_idle_gap_cs",    32'(f_cs_o),  32'(1'b0));
    chk("fx_idle_gap_grant", 32'(f_grant), 32'(3'b000));
    tick();
    tick(); f_cs = 3'b000; f_ack = 1'b0;
    @(negedge i_clk) chk("fx_idle_after", 32'(f_cs_o), 32'(1'b0));

    // Round-robin: all requesting, grants rotate 0,1,2,0 with idle gaps.
    tick(); r_ack = 1'b1; r_cs = 3'b111;
    rq.push_back(mk(2'd0, 1'b0));
    rq.push_back(mk(2'd1, 1'b0));
    rq.push_back(mk(2'd2, 1'b0));
    rq.push_back(mk(2'd0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge i_clk);
      tick();
      if (i == 3) begin
        r_cs  = 3'b000;
        r_ack = 1'b0;
      end
      @(negedge i_clk);
      chk("rr_idle_gap_cs",    32'(r_cs_o),  32'(1'b0));
      chk("rr_idle_gap_grant", 32'(r_grant), 32'(3'b000));
    end

    // Timeout: 4th ACCESS cycle completes with ack+err.
    tick(); f_cs = 3'b001;
    fq.push_back(mk(2'd0, 1'b1));
    repeat (3) begin
      tick();
      @(negedge i_clk) chk("to_early_ack", 32'(f_m_ack), 32'(3'b000));
    end
    tick();
    @(negedge i_clk) chk("to_cs_held", 32'(f_cs_o), 32'(1'b1));
    tick(); f_cs = 3'b000;
    @(negedge i_clk);
    chk("to_idle_cs",    32'(f_cs_o),  32'(1'b0));
    chk("to_idle_grant", 32'(f_grant), 32'(3'b000));

    // Ack in the timeout cycle wins: ack without err.
    tick(); f_cs = 3'b010;
    fq.push_back(mk(2'd1, 1'b0));
    repeat (3) tick();
    tick(); f_ack = 1'b1;
    @(negedge i_clk) chk("to_ack_wins_err", 32'(f_m_err), 32'(3'b000));
    tick(); f_cs = 3'b000; f_ack = 1'b0;
    @(negedge i_clk) chk("to_ack_idle_cs", 32'(f_cs_o), 32'(1'b0));

    // Abort on RR instance (pointer at 1): no ack, pointer kept.
    tick(); r_cs = 3'b010;
    tick();
    @(negedge i_clk) chk("ab_grant", 32'(r_grant), 32'(3'b010));
    tick();
    tick(); r_cs = 3'b000;
    @(negedge i_clk);
    chk("ab_cs",  32'(r_cs_o),  32'(1'b0));
    chk("ab_ack", 32'(r_m_ack), 32'(3'b000));
    chk("ab_err", 32'(r_m_err), 32'(3'b000));
    tick();
    @(negedge i_clk) chk("ab_idle_grant", 32'(r_grant), 32'(3'b000));
    tick(); r_cs = 3'b111; r_ack = 1'b1;
    rq.push_back(mk(2'd1, 1'b0));
    tick();
    tick(); r_cs = 3'b000; r_ack = 1'b0;

    // Asynchronous reset mid-access, then master 0 wins first in both modes.
    tick(); f_cs = 3'b100; r_cs = 3'b100;
    tick();
    @(negedge i_clk);
    chk("mid_fx_cs", 32'(f_cs_o), 32'(1'b1));
    chk("mid_rr_cs", 32'(r_cs_o), 32'(1'b1));
    tick(); f_ack = 1'b1; r_ack = 1'b1;
    #1;
    chk("pre_rst_ack", 32'(f_m_ack), 32'(3'b100));
    i_reset_n = 1'b0;
    #1;
    chk("arst_fx_cs",    32'(f_cs_o),  32'(1'b0));
    chk("arst_fx_grant", 32'(f_grant), 32'(3'b000));
    chk("arst_fx_ack",   32'(f_m_ack), 32'(3'b000));
    chk("arst_rr_cs",    32'(r_cs_o),  32'(1'b0));
    chk("arst_rr_grant", 32'(r_grant), 32'(3'b000));
    chk("arst_rr_ack",   32'(r_m_ack), 32'(3'b000));
    f_cs = 3'b111; r_cs = 3'b111;
    fq.push_back(mk(2'd0, 1'b0));
    rq.push_back(mk(2'd0, 1'b0));
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_reset_n = 1'b1;
    tick();
    tick(); f_cs = 3'b000; r_cs = 3'b000; f_ack = 1'b0; r_ack = 1'b0;
    repeat (3) tick();

    chk("fx_queue_drained", 32'(fq.size()), 32'd0);
    chk("rr_queue_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-master to single-slave-bus arbiter with registered grant, per-master ack/error return and a transaction timeout.
- Replaces the hard-wired two-master (UART debug master / CPU) priority mux in the computer top level.
- Supports any master count, fixed-priority or round-robin arbitration, and a watchdog that completes hung accesses with an error.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8); master 0 has the highest fixed priority
ADDR_W, 16, address width
DATA_W, 8, data width
ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
TIMEOUT_CYCLES, 255, cycles in ACCESS without slave ack before forced error completion; 0 disables the timeout

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous, active-low reset
i_m_cs  in  NUM_MASTERS  per-master request; held until that master's ack
i_m_we  in  NUM_MASTERS  per-master write enable
i_m_addr  in  NUM_MASTERS*ADDR_W  packed master addresses; master k occupies bits [k*ADDR_W +: ADDR_W]
i_m_dat  in  NUM_MASTERS*DATA_W  packed master write data
o_m_ack  out  NUM_MASTERS  one-hot completion strobe
o_m_err  out  NUM_MASTERS  one-hot error strobe; only asserted together with ack
o_m_dat  out  DATA_W  read data, broadcast to all masters; valid when that master's ack is high
o_grant  out  NUM_MASTERS  one-hot current owner; all zero when idle
o_addr  out  ADDR_W  slave bus address
o_dat  out  DATA_W  slave bus write data
o_we  out  1  slave bus write enable
o_cs  out  1  slave bus strobe
i_dat  in  DATA_W  slave read data
i_ack  in  1  slave acknowledge; level, sampled while o_cs is high

Behaviour:
- Reset, asynchronous: state=IDLE, o_grant=0, timeout counter=0, RR pointer=0.
  - Outputs during reset: o_cs=0, o_we=0, o_addr=0, o_dat=0, o_m_ack=0, o_m_err=0, o_m_dat=i_dat.
- State machine has two states: IDLE and ACCESS.
- IDLE:
  - If any i_m_cs bit is set, register the one-hot winner into o_grant and go to ACCESS. Grant latency is 1 clock after the request.
  - If no request is pending, stay in IDLE with o_grant=0.
- Fixed priority (ARB_MODE=0): the lowest set index wins.
- Round-robin (ARB_MODE=1):
  - Search starts at the RR pointer and wraps modulo NUM_MASTERS; the first set bit wins.
  - On every ack or error completion, the pointer becomes (winner index + 1) mod NUM_MASTERS.
  - An abort does not move the pointer.
- ACCESS, bus drive:
  - o_cs = granted master's cs.
  - o_addr, o_dat and o_we are muxed combinationally from the granted master.
  - In IDLE, o_cs=0 and the bus outputs are 0.
- ACCESS, ack path:
  - o_m_ack[g] = i_ack & o_cs, combinational and zero-latency.
  - o_m_dat = i_dat.
  - On the ack clock edge, go to IDLE and clear o_grant.
- Back-to-back requests:
  - There is always at least 1 idle bus cycle (o_cs=0) between transactions.
  - A master that keeps cs high after its ack re-arbitrates like any other requester.
- Abort: if the granted master drops cs before ack, go to IDLE next edge. No ack and no error are issued, and the counter is cleared.
- Timeout:
  - The counter increments each ACCESS cycle without ack and saturates.
  - When the count equals TIMEOUT_CYCLES-1 and i_ack is still low, that cycle drives o_m_ack[g]=1, o_m_err[g]=1 and o_cs=1.
  - The next edge goes to IDLE. The counter is cleared on every IDLE entry.
- Simultaneous events: if i_ack and the timeout occur in the same cycle, i_ack wins and err=0.
- Non-granted masters: requests are ignored until IDLE. A request and an ack in the same cycle are resolved by the grant, never by the current i_m_cs.
- Reset mid-access: o_cs falls immediately (asynchronous) and no ack is generated.

Decomposition:
- Package bus_arbiter_pkg holds:
  - state enum {IDLE, ACCESS};
  - ARB_FIXED=0 and ARB_RR=1 constants;
  - clog2-based index width function.
- Sub-module arb_picker is combinational: inputs are the request vector, the RR pointer and the mode; outputs are the one-hot winner and its index.
- The FSM, counter and muxes live in bus_arbiter.

Test Plan:
1. Fixed mode, i_m_cs=3'b110 held, i_ack tied 1 → grant=3'b010 one clock after the request, then (after one idle cycle) 3'b100. o_addr tracks the owner's address.
2. RR mode, all three masters requesting continuously, i_ack=1 → grant sequence 001,010,100,001 with o_cs=0 between each grant.
3. TIMEOUT_CYCLES=4, i_ack=0 → 4th ACCESS cycle shows o_m_ack=o_m_err=1 for the owner; next cycle IDLE, o_cs=0.
4. i_ack rises in the same cycle the timeout fires → ack=1, err=0.
5. Master 1 granted, drops cs after 2 cycles with no ack → IDLE next edge, no ack/err, RR pointer unchanged.
6. Assert i_reset_n=0 mid-ACCESS → o_cs, o_grant, o_m_ack drop asynchronously (before the next clock); after release, first grant is master 0 in both modes.
